// File: rtl/axis_packet_generator.sv
// rtl/axis_packet_generator.sv - AXI-Stream master emitting packets of incrementing-counter data
module axis_packet_generator #(
  parameter int DATAWIDTH = 64,
  parameter int LENWIDTH  = 16,
  parameter int GAPWIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LENWIDTH-1:0]  pkt_len,
  input  logic [LENWIDTH-1:0]  pkt_count,
  input  logic [GAPWIDTH-1:0]  gap_cycles,
  output logic [DATAWIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          pkts_sent
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t               state;
  logic [LENWIDTH-1:0]  len_r;
  logic [LENWIDTH-1:0]  count_r;
  logic [GAPWIDTH-1:0]  gap_r;
  logic [LENWIDTH-1:0]  beat;
  logic [LENWIDTH-1:0]  pkt_cnt;
  logic [GAPWIDTH-1:0]  gap_cnt;
  logic                 stop_pending;

  logic xfer;
  logic last_pkt;

  assign xfer     = m_axis_tvalid & m_axis_tready;
  // pkt_count of zero means free-running, so it never completes the run on its own
  assign last_pkt = (count_r != '0) && ((pkt_cnt + LENWIDTH'(1)) == count_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      len_r         <= '0;
      count_r       <= '0;
      gap_r         <= '0;
      beat          <= '0;
      pkt_cnt       <= '0;
      gap_cnt       <= '0;
      stop_pending  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pkts_sent     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_SEND;
            len_r         <= (pkt_len == '0) ? LENWIDTH'(1) : pkt_len;
            count_r       <= pkt_count;
            gap_r         <= gap_cycles;
            beat          <= '0;
            pkt_cnt       <= '0;
            stop_pending  <= stop;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (pkt_len <= LENWIDTH'(1));
            busy          <= 1'b1;
            pkts_sent     <= '0;
          end
        end

        S_SEND: begin
          if (stop) stop_pending <= 1'b1;
          if (xfer) begin
            m_axis_tdata <= m_axis_tdata + DATAWIDTH'(1);
            if (m_axis_tlast) begin
              beat    <= '0;
              pkt_cnt <= pkt_cnt + LENWIDTH'(1);
              if (pkts_sent != '1) pkts_sent <= pkts_sent + 32'd1;
              if (last_pkt || stop_pending) begin
                state         <= S_IDLE;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                busy          <= 1'b0;
                done          <= 1'b1;
                stop_pending  <= 1'b0;
              end else if (gap_r == '0) begin
                m_axis_tlast <= (len_r == LENWIDTH'(1));
              end else begin
                state         <= S_GAP;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                gap_cnt       <= gap_r;
              end
            end else begin
              beat         <= beat + LENWIDTH'(1);
              // tlast for the beat that will be presented next
              m_axis_tlast <= ((beat + LENWIDTH'(2)) == len_r);
            end
          end
        end

        S_GAP: begin
          if (stop) stop_pending <= 1'b1;
          if (gap_cnt <= GAPWIDTH'(1)) begin
            if (stop_pending) begin
              state        <= S_IDLE;
              busy         <= 1'b0;
              done         <= 1'b1;
              stop_pending <= 1'b0;
            end else begin
              state         <= S_SEND;
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= (len_r == LENWIDTH'(1));
            end
          end else begin
            gap_cnt <= gap_cnt - GAPWIDTH'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_generator.sv
// tb/tb_axis_packet_generator.sv - scoreboard bench for axis_packet_generator
module tb_axis_packet_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] pkt_len = '0;
  logic [15:0] pkt_count = '0;
  logic [7:0]  gap_cycles = '0;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic        busy;
  logic        done;
  logic [31:0] pkts_sent;

  axis_packet_generator #(.DATAWIDTH(64), .LENWIDTH(16), .GAPWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .pkt_len(pkt_len), .pkt_count(pkt_count), .gap_cycles(gap_cycles),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .busy(busy), .done(done), .pkts_sent(pkts_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        last;
    int          gap;   // tvalid-low cycles expected before this beat, -1 = don't care
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;
  int   nxfer = 0;
  int   cyc = 0;
  int   last_xfer_cyc = 0;
  int   idle_cnt = 0;
  bit   rnd_ready = 0;
  bit   hold = 0;
  logic [63:0] prev_data;
  logic        prev_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on each accepted beat and checks hold-while-stalled
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 0;
      idle_cnt = 0;
    end else begin
      if (hold) begin
        chk("stall tvalid held", 64'(m_axis_tvalid), 64'd1);
        chk("stall tdata held", m_axis_tdata, prev_data);
        chk("stall tlast held", 64'(m_axis_tlast), 64'(prev_last));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (sbq.size() == 0) begin
          checks++;
          $display("FAIL unexpected beat: got tdata %0h expected no beat", m_axis_tdata);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("beat tdata", m_axis_tdata, e.data);
          chk("beat tlast", 64'(m_axis_tlast), 64'(e.last));
          if (e.gap >= 0) chk("gap before beat", 64'(idle_cnt), 64'(e.gap));
        end
        nxfer++;
        last_xfer_cyc = cyc;
        idle_cnt = 0;
      end else if (!m_axis_tvalid) begin
        idle_cnt++;
      end
      hold = m_axis_tvalid && !m_axis_tready;
      prev_data = m_axis_tdata;
      prev_last = m_axis_tlast;
    end
  end

  task automatic push_run(input int beats, input int len, input int gap);
    for (int i = 0; i < beats; i++) begin
      exp_t e;
      e.data = 64'(i);
      e.last = ((i % len) == len - 1);
      e.gap  = (i == 0) ? -1 : (((i % len) == 0) ? gap : 0);
      sbq.push_back(e);
    end
  endtask

  task automatic do_start(input int len, input int cnt, input int gap, input bit with_stop);
    @(posedge clk); #1;
    pkt_len = 16'(len);
    pkt_count = 16'(cnt);
    gap_cycles = 8'(gap);
    start = 1'b1;
    stop = with_stop;
    @(posedge clk); #1;
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic wait_xfers(input string name, input int target);
    int n = 0;
    while (nxfer < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      $display("FAIL %s timeout: got %0d beats expected %0d", name, nxfer, target);
    end
  endtask

  task automatic wait_done(input string name, input int exp_pkts, input bit chk_lat);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, " done seen"}, 64'(done), 64'd1);
    if (chk_lat) chk({name, " done latency"}, 64'(cyc - last_xfer_cyc), 64'd1);
    chk({name, " pkts_sent"}, 64'(pkts_sent), 64'(exp_pkts));
    @(negedge clk);
    chk({name, " done pulse width"}, 64'(done), 64'd0);
    chk({name, " busy low"}, 64'(busy), 64'd0);
    chk({name, " scoreboard empty"}, 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    int base;
    #3;
    chk("reset tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("reset tdata", m_axis_tdata, 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset pkts_sent", 64'(pkts_sent), 64'd0);
    #9 rst_n = 1'b1;

    // T1 back-to-back packets
    push_run(8, 4, 0);
    do_start(4, 2, 0, 0);
    chk("T1 busy", 64'(busy), 64'd1);
    wait_done("T1", 2, 1);

    // T2 inter-packet gap of 5
    push_run(6, 3, 5);
    do_start(3, 2, 5, 0);
    wait_done("T2", 2, 1);

    // T3 random back-pressure
    rnd_ready = 1;
    push_run(8, 8, 0);
    do_start(8, 1, 0, 0);
    wait_done("T3", 1, 0);
    rnd_ready = 0;

    // T4 free-running, stop during third packet
    push_run(15, 5, 0);
    base = nxfer;
    do_start(5, 0, 0, 0);
    wait_xfers("T4", base + 12);
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_done("T4", 3, 1);

    // T5 zero length acts as one; start while busy ignored
    push_run(3, 1, 0);
    do_start(0, 3, 0, 0);
    pkt_len = 16'd7;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("T5", 3, 1);

    // T7 start and stop together: exactly one packet
    push_run(2, 2, 0);
    do_start(2, 0, 0, 1);
    wait_done("T7", 1, 1);

    // T6 asynchronous reset mid-packet, then clean restart
    push_run(6, 6, 0);
    base = nxfer;
    do_start(6, 1, 0, 0);
    wait_xfers("T6", base + 3);
    #2 rst_n = 1'b0;
    #1;
    chk("T6 async tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("T6 async tdata", m_axis_tdata, 64'd0);
    chk("T6 async tlast", 64'(m_axis_tlast), 64'd0);
    chk("T6 async busy", 64'(busy), 64'd0);
    chk("T6 async pkts_sent", 64'(pkts_sent), 64'd0);
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_run(2, 2, 0);
    do_start(2, 1, 0, 0);
    wait_done("T6 restart", 1, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
